// File: rtl/pump_pkg.sv
// rtl/pump_pkg.sv - shared encodings for the pump controller
package pump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_FILLING = 2'b01,
        ST_HOLDOFF = 2'b10,
        ST_FAULT   = 2'b11
    } state_t;

    localparam logic [1:0] LVL_UNKNOWN = 2'b00;
    localparam logic [1:0] LVL_EMPTY   = 2'b01;
    localparam logic [1:0] LVL_HALF    = 2'b10;
    localparam logic [1:0] LVL_FULL    = 2'b11;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_DRY_RUN = 2'b01;
    localparam logic [1:0] FC_SENSOR  = 2'b10;

    // One-hot {full,half,empty} maps to a level code; anything else,
    // including X/Z bits (case matches exactly), maps to LVL_UNKNOWN.
    function automatic logic [1:0] decode_level(input logic [2:0] flags);
        case (flags)
            3'b001:  return LVL_EMPTY;
            3'b010:  return LVL_HALF;
            3'b100:  return LVL_FULL;
            default: return LVL_UNKNOWN;
        endcase
    endfunction

endpackage

// File: rtl/pump_controller_level_debounce.sv
// rtl/pump_controller_level_debounce.sv - level flag validation and debounce
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   full, half, empty   : raw level flags
//   level_q             : debounced level code (holds on invalid input)
//   sensor_fault        : DEBOUNCE_CYCLES consecutive invalid samples seen
module level_debounce
    import pump_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       full,
    input  logic       half,
    input  logic       empty,
    output logic [1:0] level_q,
    output logic       sensor_fault
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    sample;
    logic [1:0]    cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic          stable;

    // Invalid samples are tracked as their own class (LVL_UNKNOWN), so a run
    // of invalid patterns debounces exactly like a run of a valid level.
    always_comb begin
        sample = decode_level({full, half, empty});
        if (sample != cand) begin
            cnt_d = CW'(1);
        end else if (cnt == CNT_MAX) begin
            cnt_d = cnt;
        end else begin
            cnt_d = cnt + 1'b1;
        end
        stable = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand         <= LVL_UNKNOWN;
            cnt          <= '0;
            level_q      <= LVL_UNKNOWN;
            sensor_fault <= 1'b0;
        end else begin
            cand         <= sample;
            cnt          <= cnt_d;
            if (stable && sample != LVL_UNKNOWN) begin
                level_q <= sample;
            end
            sensor_fault <= stable && (sample == LVL_UNKNOWN);
        end
    end

endmodule

// File: rtl/pump_controller.sv
// rtl/pump_controller.sv - tank fill pump FSM with holdoff and fault timers
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   full, half, empty   : raw level flags
//   enable              : operator permission to run
//   fault_clr           : single-cycle fault acknowledge
//   pump_on             : registered pump drive
//   fault, fault_code   : latched fault and its cause
//   level_q             : debounced level code
//   state               : current FSM state
module pump_controller
    import pump_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_OFF_CYCLES  = 16,
    parameter int MAX_FILL_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       full,
    input  logic       half,
    input  logic       empty,
    input  logic       enable,
    input  logic       fault_clr,
    output logic       pump_on,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [1:0] level_q,
    output logic [1:0] state
);

    localparam int FW = $clog2(MAX_FILL_CYCLES + 1);
    localparam int HW = $clog2(MIN_OFF_CYCLES + 1);
    localparam logic [FW-1:0] FILL_LAST = FW'(MAX_FILL_CYCLES - 1);
    localparam logic [FW-1:0] FILL_MAX  = FW'(MAX_FILL_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_OFF_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MIN_OFF_CYCLES);

    state_t        state_q;
    state_t        state_d;
    logic [1:0]    code_d;
    logic [FW-1:0] fill_cnt;
    logic [HW-1:0] hold_cnt;
    logic          sensor_fault;

    level_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .full        (full),
        .half        (half),
        .empty       (empty),
        .level_q     (level_q),
        .sensor_fault(sensor_fault)
    );

    always_comb begin
        state_d = state_q;
        code_d  = fault_code;
        if (sensor_fault) begin
            // Sensor fault beats every other transition, including fault_clr.
            state_d = ST_FAULT;
            code_d  = FC_SENSOR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable && level_q == LVL_EMPTY) begin
                        state_d = ST_FILLING;
                    end
                end
                ST_FILLING: begin
                    // Half is deliberately ignored here: only full stops a fill.
                    if (level_q == LVL_FULL || !enable) begin
                        state_d = ST_HOLDOFF;
                    end else if (fill_cnt == FILL_LAST) begin
                        state_d = ST_FAULT;
                        code_d  = FC_DRY_RUN;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        state_d = ST_HOLDOFF;
                        code_d  = FC_NONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so pump_on and fault track
    // the state register on the same edge without a combinational path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fill_cnt   <= '0;
            hold_cnt   <= '0;
            pump_on    <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
        end else begin
            state_q    <= state_d;
            pump_on    <= (state_d == ST_FILLING);
            fault      <= (state_d == ST_FAULT);
            fault_code <= code_d;

            if (state_d == ST_FILLING && state_q != ST_FILLING) begin
                fill_cnt <= '0;
            end else if (state_q == ST_FILLING && fill_cnt != FILL_MAX) begin
                fill_cnt <= fill_cnt + 1'b1;
            end

            if (state_d == ST_HOLDOFF && state_q != ST_HOLDOFF) begin
                hold_cnt <= '0;
            end else if (state_q == ST_HOLDOFF && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: doc/pump_controller.md
PUMP_CONTROLLER -- requirements
Module: pump_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive identical samples needed to accept a level change.
REQ-002 SHALL have parameter MIN_OFF_CYCLES, default 16: pump rest time after every stop.
REQ-003 SHALL have parameter MAX_FILL_CYCLES, default 1024: fill timeout, i.e. the dry-run/stuck-sensor limit.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports full, half, empty, inputs, 1 bit each: level flags from the level indicator stage.
REQ-007 SHALL have port enable, input, 1 bit: operator permission to run the pump.
REQ-008 SHALL have port fault_clr, input, 1 bit: single-cycle fault acknowledge.
REQ-009 SHALL have port pump_on, output, 1 bit: pump drive.
REQ-010 SHALL have port fault, output, 1 bit: latched fault indication.
REQ-011 SHALL have port fault_code, output, 2 bits: 00 none, 01 dry-run timeout, 10 sensor invalid.
REQ-012 SHALL have port level_q, output, 2 bits: debounced level, 00 unknown, 01 empty, 10 half, 11 full.
REQ-013 SHALL have port state, output, 2 bits: current FSM state, for debug.

Function
REQ-014 SHALL treat the triple {full,half,empty} as valid only when exactly one flag is 1; all other combinations, including X, SHALL be invalid.
REQ-015 SHALL update level_q only after DEBOUNCE_CYCLES consecutive identical valid samples; any differing sample SHALL restart the count.
REQ-016 SHALL raise a sensor fault after DEBOUNCE_CYCLES consecutive invalid samples; level_q SHALL hold its last value.
REQ-017 SHALL implement the FSM states IDLE=00, FILLING=01, HOLDOFF=10 and FAULT=11.
REQ-018 IDLE: pump off; SHALL go to FILLING when enable=1 and level_q=empty; otherwise SHALL stay in IDLE.
REQ-019 FILLING: pump on, fill counter increments each cycle; SHALL go to HOLDOFF on level_q=full or enable=0.
REQ-020 FILLING: half SHALL NOT stop the pump (hysteresis); refill SHALL start only from empty.
REQ-021 FILLING: SHALL go to FAULT with fault_code=01 when the fill counter reaches MAX_FILL_CYCLES-1 without level_q=full.
REQ-022 HOLDOFF: pump off; SHALL go to IDLE after exactly MIN_OFF_CYCLES cycles in the state.
REQ-023 Any state: a sensor fault SHALL force FAULT with fault_code=10 on the next edge; it SHALL override all other transitions.
REQ-024 FAULT: pump off, fault=1; fault_clr SHALL go to HOLDOFF and clear fault_code, but only if no sensor fault is active in that cycle.
REQ-025 Simultaneous fault_clr and a new fault condition: fault SHALL win and FAULT SHALL be retained.
REQ-026 pump_on SHALL be a registered decode of state==FILLING; there is no combinational path from inputs to outputs.
REQ-027 Latency from a stable empty (enable=1) to pump_on=1 SHALL be DEBOUNCE_CYCLES+1 clock edges; the same latency SHALL apply from full to pump_on=0.
REQ-028 Counters SHALL be $clog2(param+1) bits wide and SHALL saturate, never wrap.
REQ-029 The fill counter SHALL clear on entry to FILLING; the holdoff counter SHALL clear on entry to HOLDOFF.

Reset
REQ-030 While rst=1 at an edge: state=IDLE, pump_on=0, fault=0, fault_code=00, level_q=00, and all counters=0.
REQ-031 Reset mid-fill SHALL drop pump_on on the same edge; HOLDOFF is NOT enforced after reset.
REQ-032 After reset, the pump SHALL NOT start until a debounced empty is established.

Structure
REQ-033 A shared package pump_pkg SHALL hold the state encoding, the level codes (00/01/10/11) and the fault codes.
REQ-034 Sub-module level_debounce SHALL contain the validity check, the debounce counter, level_q and the sensor-fault output; the FSM and its timers SHALL live in pump_controller.
REQ-035 The expected RTL size is 150-300 lines in total.

Verification (DEBOUNCE=4, MIN_OFF=16, MAX_FILL=64)
REQ-036 Normal cycle: enable=1, empty held 4 cycles -> pump_on=1 at edge 5; then full held 4 cycles -> pump_on=0 at edge 5, HOLDOFF for 16 cycles, then IDLE.
REQ-037 Glitch: empty for 3 cycles, half for 1 cycle, empty for 3 cycles -> level_q stays unchanged and pump_on stays 0.
REQ-038 Dry run: FILLING with full never asserted -> after 64 cycles fault=1, fault_code=01, pump_on=0; fault_clr -> HOLDOFF, then IDLE.
REQ-039 Invalid sensor: triple 3'b011 for 4 cycles during FILLING -> FAULT with fault_code=10 and pump_on=0; fault_clr while still invalid -> remains in FAULT.
REQ-040 Reset in FILLING at cycle 10 -> all outputs at reset values on that edge; re-entering FILLING needs a fresh debounced empty.
REQ-041 enable dropped mid-fill -> HOLDOFF on the next edge; re-asserting enable with empty held -> FILLING only after the 16-cycle holdoff.
